// File: rtl/flatten_stream.sv
// -----------------------------------------------------------------------------
// flatten_stream
//
// Sequential flattener between the pooling output buffer and the FC layer.
// Reads the pooled feature maps one element per cycle and re-emits them as a
// 1D stream over a valid/ready handshake. Each element carries its flattened
// index and a last marker.
//
// Ordering (latched when a start is accepted):
//   order_mode = 0 : channel-major (feature, row, col), col fastest
//   order_mode = 1 : spatial-major (row, col, feature), feature fastest
//
// Optional feature macro: FLATTEN_RELU_EN
//   When defined, negative elements are clamped to 0 as they enter the
//   output FIFO. When undefined, data passes through unmodified.
//
// Ports:
//   clock, reset       rising-edge clock, synchronous active-high reset
//   flatten_start      one-cycle pulse that starts a pass (IDLE only)
//   order_mode         ordering select, sampled at accepted start
//   rd_en              read strobe to the pooled buffer
//   rd_feature/row/col read address
//   rd_data            read data, valid one cycle after rd_en
//   out_valid/ready    output handshake
//   out_data           flattened element (signed)
//   out_index          position in the flattened vector
//   out_last           marks index FLATTENED_LENGTH-1
//   busy               high from accepted start until done
//   done               one-cycle pulse after the last element handshakes
// -----------------------------------------------------------------------------
module flatten_stream #(
    parameter int NUM_FEATURES     = 3,
    parameter int POOLED_HEIGHT    = 12,
    parameter int POOLED_WIDTH     = 12,
    parameter int DATA_WIDTH       = 8,
    parameter int FLATTENED_LENGTH = NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH,
    parameter int IDX_WIDTH        = (FLATTENED_LENGTH > 1) ? $clog2(FLATTENED_LENGTH) : 1,
    // Derived address widths; kept at least 1 bit for degenerate dimensions.
    parameter int FEAT_WIDTH       = (NUM_FEATURES  > 1) ? $clog2(NUM_FEATURES)  : 1,
    parameter int ROW_WIDTH        = (POOLED_HEIGHT > 1) ? $clog2(POOLED_HEIGHT) : 1,
    parameter int COL_WIDTH        = (POOLED_WIDTH  > 1) ? $clog2(POOLED_WIDTH)  : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         flatten_start,
    input  logic                         order_mode,
    output logic                         rd_en,
    output logic [FEAT_WIDTH-1:0]        rd_feature,
    output logic [ROW_WIDTH-1:0]         rd_row,
    output logic [COL_WIDTH-1:0]         rd_col,
    input  logic signed [DATA_WIDTH-1:0] rd_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] out_data,
    output logic [IDX_WIDTH-1:0]         out_index,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done
);

    if (FLATTENED_LENGTH != NUM_FEATURES * POOLED_HEIGHT * POOLED_WIDTH) begin : g_len_check
        $error("flatten_stream: FLATTENED_LENGTH inconsistent with NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH");
    end

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                         state_r;
    logic                           mode_r;
    logic [FEAT_WIDTH-1:0]          feat_r;
    logic [ROW_WIDTH-1:0]           row_r;
    logic [COL_WIDTH-1:0]           col_r;
    logic [IDX_WIDTH-1:0]           issue_idx_r;
    logic                           inflight_r;
    logic [IDX_WIDTH-1:0]           infl_idx_r;
    logic                           infl_last_r;
    logic                           busy_r;
    logic                           done_r;

    // Two-entry output FIFO; index and last travel alongside the data.
    logic signed [DATA_WIDTH-1:0]   data_mem_r [2];
    logic [IDX_WIDTH-1:0]           idx_mem_r  [2];
    logic                           last_mem_r [2];
    logic                           wr_ptr_r;
    logic                           rd_ptr_r;
    logic [1:0]                     count_r;

    logic                           pop_s;
    logic                           push_s;
    logic [2:0]                     occ_s;
    logic                           rd_en_s;
    logic                           issue_last_s;
    logic                           feat_wrap_s;
    logic                           row_wrap_s;
    logic                           col_wrap_s;
    logic [FEAT_WIDTH-1:0]          feat_nxt_s;
    logic [ROW_WIDTH-1:0]           row_nxt_s;
    logic [COL_WIDTH-1:0]           col_nxt_s;
    logic signed [DATA_WIDTH-1:0]   push_data_s;

    assign pop_s        = (count_r != 2'd0) && out_ready;
    assign push_s       = inflight_r;
    // Occupancy after this cycle's pop, counting the read already in flight.
    assign occ_s        = 3'(count_r) + 3'(inflight_r) - 3'(pop_s);
    assign rd_en_s      = (state_r == RUN) && (occ_s < 3'd2);
    assign issue_last_s = (issue_idx_r == IDX_WIDTH'(FLATTENED_LENGTH - 1));
    assign feat_wrap_s  = (feat_r == FEAT_WIDTH'(NUM_FEATURES - 1));
    assign row_wrap_s   = (row_r  == ROW_WIDTH'(POOLED_HEIGHT - 1));
    assign col_wrap_s   = (col_r  == COL_WIDTH'(POOLED_WIDTH - 1));

`ifdef FLATTEN_RELU_EN
    assign push_data_s  = rd_data[DATA_WIDTH-1] ? '0 : rd_data;
`else
    assign push_data_s  = rd_data;
`endif

    // Next read address: nested wrap counters whose nesting depends on mode.
    always_comb begin
        feat_nxt_s = feat_r;
        row_nxt_s  = row_r;
        col_nxt_s  = col_r;
        if (mode_r == 1'b0) begin
            if (!col_wrap_s) begin
                col_nxt_s = col_r + COL_WIDTH'(1);
            end else begin
                col_nxt_s = '0;
                if (!row_wrap_s) begin
                    row_nxt_s = row_r + ROW_WIDTH'(1);
                end else begin
                    row_nxt_s  = '0;
                    feat_nxt_s = feat_wrap_s ? '0 : feat_r + FEAT_WIDTH'(1);
                end
            end
        end else begin
            if (!feat_wrap_s) begin
                feat_nxt_s = feat_r + FEAT_WIDTH'(1);
            end else begin
                feat_nxt_s = '0;
                if (!col_wrap_s) begin
                    col_nxt_s = col_r + COL_WIDTH'(1);
                end else begin
                    col_nxt_s = '0;
                    row_nxt_s = row_wrap_s ? '0 : row_r + ROW_WIDTH'(1);
                end
            end
        end
    end

    // Control FSM, address counters, in-flight read tracking, busy/done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            mode_r      <= 1'b0;
            feat_r      <= '0;
            row_r       <= '0;
            col_r       <= '0;
            issue_idx_r <= '0;
            inflight_r  <= 1'b0;
            infl_idx_r  <= '0;
            infl_last_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            inflight_r  <= rd_en_s;
            infl_idx_r  <= issue_idx_r;
            infl_last_r <= issue_last_s;
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (flatten_start) begin
                        state_r     <= RUN;
                        mode_r      <= order_mode;
                        feat_r      <= '0;
                        row_r       <= '0;
                        col_r       <= '0;
                        issue_idx_r <= '0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    if (rd_en_s) begin
                        feat_r      <= feat_nxt_s;
                        row_r       <= row_nxt_s;
                        col_r       <= col_nxt_s;
                        issue_idx_r <= issue_idx_r + IDX_WIDTH'(1);
                        state_r     <= issue_last_s ? DRAIN : RUN;
                    end else begin
                        state_r <= RUN;
                    end
                end
                DRAIN: begin
                    if (pop_s && out_last) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        state_r <= DRAIN;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    done_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    // Output FIFO: push the returning read, pop on handshake.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_mem_r[0] <= '0;
            data_mem_r[1] <= '0;
            idx_mem_r[0]  <= '0;
            idx_mem_r[1]  <= '0;
            last_mem_r[0] <= 1'b0;
            last_mem_r[1] <= 1'b0;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            count_r       <= 2'd0;
        end else begin
            if (push_s) begin
                data_mem_r[wr_ptr_r] <= push_data_s;
                idx_mem_r[wr_ptr_r]  <= infl_idx_r;
                last_mem_r[wr_ptr_r] <= infl_last_r;
                wr_ptr_r             <= ~wr_ptr_r;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            rd_ptr_r <= pop_s ? ~rd_ptr_r : rd_ptr_r;
            count_r  <= count_r + 2'(push_s) - 2'(pop_s);
        end
    end

    assign rd_en      = rd_en_s;
    assign rd_feature = feat_r;
    assign rd_row     = row_r;
    assign rd_col     = col_r;
    assign out_valid  = (count_r != 2'd0);
    assign out_data   = data_mem_r[rd_ptr_r];
    assign out_index  = idx_mem_r[rd_ptr_r];
    assign out_last   = last_mem_r[rd_ptr_r];
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_flatten_stream.sv
// -----------------------------------------------------------------------------
// tb_flatten_stream
//
// Directed bench for flatten_stream with F=2, H=2, W=3, DATA_WIDTH=8.
// The buffer model returns 16*f + 4*r + c one cycle after rd_en, with a few
// override values used by the clamping scenario.
// -----------------------------------------------------------------------------
module tb_flatten_stream;

    logic               clock = 1'b0;
    logic               reset;
    logic               flatten_start;
    logic               order_mode;
    logic               rd_en;
    logic [0:0]         rd_feature;
    logic [0:0]         rd_row;
    logic [1:0]         rd_col;
    logic signed [7:0]  rd_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [7:0]  out_data;
    logic [3:0]         out_index;
    logic               out_last;
    logic               busy;
    logic               done;

    int pass_cnt  = 0;
    int check_cnt = 0;
    bit use_override = 1'b0;

    int exp0 [12] = '{0, 1, 2, 4, 5, 6, 16, 17, 18, 20, 21, 22};
    int exp1 [12] = '{0, 16, 1, 17, 2, 18, 4, 20, 5, 21, 6, 22};

    // Results collected by run_pass
    logic [7:0] got_data [$];
    int         got_idx  [$];
    bit         got_last [$];
    int         valid_cycles, first_valid_cyc, last_valid_cyc;
    int         done_cnt, done_cyc, last_hs_cyc, busy_at0;
    int         stall_err, issue_err;
    bit         timed_out;

    flatten_stream #(
        .NUM_FEATURES (2),
        .POOLED_HEIGHT(2),
        .POOLED_WIDTH (3),
        .DATA_WIDTH   (8)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .flatten_start(flatten_start),
        .order_mode   (order_mode),
        .rd_en        (rd_en),
        .rd_feature   (rd_feature),
        .rd_row       (rd_row),
        .rd_col       (rd_col),
        .rd_data      (rd_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_index    (out_index),
        .out_last     (out_last),
        .busy         (busy),
        .done         (done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] model_elem(input int f, input int r, input int c);
        if (use_override && f == 0 && r == 0 && c == 1) return 8'hFB;  // -5
        if (use_override && f == 0 && r == 1 && c == 1) return 8'h7F;  // 127
        if (use_override && f == 1 && r == 1 && c == 0) return 8'h80;  // -128
        return 8'(16 * f + 4 * r + c);
    endfunction

    // Pooled buffer model: one-cycle read latency, junk when not reading.
    always @(posedge clock) begin
        if (rd_en === 1'b1)
            rd_data <= model_elem(int'(rd_feature), int'(rd_row), int'(rd_col));
        else
            rd_data <= 8'sh5A;
    end

    // Runs one pass and records every handshaken element plus timing facts.
    // restart_at: element count at which a second start is pulsed (-1 none).
    // stop_after: return right after recording this element (-1 run to done).
    task automatic run_pass(input bit mode, input bit toggle_ready,
                            input int restart_at, input int stop_after);
        int cnt_b, infl_b, pend, stop_at;
        bit pop, prev_stall, ready_ph, prev_last;
        logic [7:0] prev_data;
        logic [3:0] prev_idx;
        got_data.delete(); got_idx.delete(); got_last.delete();
        valid_cycles = 0; first_valid_cyc = -1; last_valid_cyc = -1;
        done_cnt = 0; done_cyc = -1; last_hs_cyc = -1; busy_at0 = 0;
        stall_err = 0; issue_err = 0; timed_out = 1'b1;
        cnt_b = 0; infl_b = 0; prev_stall = 1'b0; ready_ph = 1'b1; stop_at = 400;
        prev_data = 8'h00; prev_idx = 4'h0; prev_last = 1'b0;
        @(negedge clock);
        flatten_start = 1'b1; order_mode = mode; out_ready = 1'b1;
        for (int cyc = 0; cyc < stop_at; cyc++) begin
            @(negedge clock);
            flatten_start = 1'b0;
            if (toggle_ready) begin
                out_ready = ready_ph;
                ready_ph  = ~ready_ph;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (cyc == 0) busy_at0 = int'(busy);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
                if (timed_out) begin
                    timed_out = 1'b0;
                    stop_at   = cyc + 4;
                end
            end
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data ||
                               out_index !== prev_idx || out_last !== prev_last))
                stall_err++;
            if (out_valid === 1'b1) begin
                valid_cycles++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                last_valid_cyc = cyc;
            end
            pop  = (out_valid === 1'b1) && (out_ready === 1'b1);
            if ((cnt_b != 0) != (out_valid === 1'b1)) issue_err++;
            pend = cnt_b + infl_b - int'(pop);
            if (rd_en === 1'b1 && pend >= 2) issue_err++;
            cnt_b  = pend;
            infl_b = int'(rd_en === 1'b1);
            prev_stall = (out_valid === 1'b1) && (out_ready === 1'b0);
            prev_data  = out_data; prev_idx = out_index; prev_last = out_last;
            if (pop) begin
                got_data.push_back(out_data);
                got_idx.push_back(int'(out_index));
                got_last.push_back(out_last);
                last_hs_cyc = cyc;
                if (restart_at >= 0 && got_data.size() == restart_at + 1) begin
                    flatten_start = 1'b1;
                    order_mode    = ~mode;
                end
                if (stop_after >= 0 && got_data.size() == stop_after + 1) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flatten_start = 1'b0; order_mode = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clock);
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", out_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
        check_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
        check_cnt++; if (rd_en !== 1'b0) $display("FAIL reset_rd_en got %b exp 0", rd_en); else pass_cnt++;
        check_cnt++; if (out_data !== 8'sh00) $display("FAIL reset_out_data got %h exp 00", out_data); else pass_cnt++;
        check_cnt++; if (out_index !== 4'h0) $display("FAIL reset_out_index got %h exp 0", out_index); else pass_cnt++;
        check_cnt++; if (out_last !== 1'b0) $display("FAIL reset_out_last got %b exp 0", out_last); else pass_cnt++;
        check_cnt++; if ({rd_feature, rd_row, rd_col} !== 4'h0) $display("FAIL reset_rd_addr got %h exp 0", {rd_feature, rd_row, rd_col}); else pass_cnt++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        check_cnt++; if (busy !== 1'b0 || rd_en !== 1'b0) $display("FAIL idle_no_start busy=%b rd_en=%b exp 0 0", busy, rd_en); else pass_cnt++;
    endtask

    task automatic test_mode0();
        run_pass(1'b0, 1'b0, -1, -1);
        check_cnt++; if (timed_out) $display("FAIL m0_timeout got no done exp done"); else pass_cnt++;
        check_cnt++; if (got_data.size() != 12) $display("FAIL m0_count got %0d exp 12", got_data.size()); else pass_cnt++;
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check_cnt++; if (got_data[i] !== 8'(exp0[i])) $display("FAIL m0_data[%0d] got %0d exp %0d", i, got_data[i], exp0[i]); else pass_cnt++;
            check_cnt++; if (got_idx[i] != i) $display("FAIL m0_index[%0d] got %0d exp %0d", i, got_idx[i], i); else pass_cnt++;
            check_cnt++; if (got_last[i] != (i == 11)) $display("FAIL m0_last[%0d] got %b exp %b", i, got_last[i], i == 11); else pass_cnt++;
        end
        check_cnt++; if (busy_at0 != 1) $display("FAIL m0_busy_start got %0d exp 1", busy_at0); else pass_cnt++;
        check_cnt++; if (first_valid_cyc != 2) $display("FAIL m0_first_valid got %0d exp 2", first_valid_cyc); else pass_cnt++;
        check_cnt++; if (valid_cycles != 12 || last_valid_cyc - first_valid_cyc != 11)
            $display("FAIL m0_consecutive got %0d valid over %0d cycles exp 12 over 12", valid_cycles, last_valid_cyc - first_valid_cyc + 1); else pass_cnt++;
        check_cnt++; if (done_cnt != 1) $display("FAIL m0_done_count got %0d exp 1", done_cnt); else pass_cnt++;
        check_cnt++; if (done_cyc != last_hs_cyc + 1) $display("FAIL m0_done_timing got %0d exp %0d", done_cyc, last_hs_cyc + 1); else pass_cnt++;
        check_cnt++; if (issue_err != 0) $display("FAIL m0_issue_rule got %0d violations exp 0", issue_err); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL m0_busy_end got %b exp 0", busy); else pass_cnt++;
    endtask

    task automatic test_mode1();
        run_pass(1'b1, 1'b0, -1, -1);
        check_cnt++; if (got_data.size() != 12) $display("FAIL m1_count got %0d exp 12", got_data.size()); else pass_cnt++;
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check_cnt++; if (got_data[i] !== 8'(exp1[i])) $display("FAIL m1_data[%0d] got %0d exp %0d", i, got_data[i], exp1[i]); else pass_cnt++;
            check_cnt++; if (got_idx[i] != i) $display("FAIL m1_index[%0d] got %0d exp %0d", i, got_idx[i], i); else pass_cnt++;
            check_cnt++; if (got_last[i] != (i == 11)) $display("FAIL m1_last[%0d] got %b exp %b", i, got_last[i], i == 11); else pass_cnt++;
        end
        check_cnt++; if (done_cnt != 1) $display("FAIL m1_done_count got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_stall();
        run_pass(1'b0, 1'b1, -1, -1);
        check_cnt++; if (got_data.size() != 12) $display("FAIL stall_count got %0d exp 12", got_data.size()); else pass_cnt++;
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check_cnt++; if (got_data[i] !== 8'(exp0[i]) || got_idx[i] != i)
                $display("FAIL stall_elem[%0d] got %0d@%0d exp %0d@%0d", i, got_data[i], got_idx[i], exp0[i], i); else pass_cnt++;
        end
        check_cnt++; if (stall_err != 0) $display("FAIL stall_hold got %0d changes exp 0", stall_err); else pass_cnt++;
        check_cnt++; if (issue_err != 0) $display("FAIL stall_issue_rule got %0d violations exp 0", issue_err); else pass_cnt++;
        check_cnt++; if (done_cnt != 1) $display("FAIL stall_done_count got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        run_pass(1'b0, 1'b0, 5, -1);
        check_cnt++; if (got_data.size() != 12) $display("FAIL restart_count got %0d exp 12", got_data.size()); else pass_cnt++;
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check_cnt++; if (got_data[i] !== 8'(exp0[i]) || got_idx[i] != i)
                $display("FAIL restart_elem[%0d] got %0d@%0d exp %0d@%0d", i, got_data[i], got_idx[i], exp0[i], i); else pass_cnt++;
        end
        check_cnt++; if (done_cnt != 1) $display("FAIL restart_done_count got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int late_done;
        run_pass(1'b0, 1'b0, -1, 7);
        check_cnt++; if (timed_out || got_data.size() != 8) $display("FAIL rst_mid_reach got %0d elems exp 8", got_data.size()); else pass_cnt++;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        #1;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid got %b exp 0", out_valid); else pass_cnt++;
        check_cnt++; if (busy !== 1'b0) $display("FAIL rst_mid_busy got %b exp 0", busy); else pass_cnt++;
        late_done = int'(done === 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            if (done === 1'b1) late_done++;
        end
        check_cnt++; if (late_done != 0) $display("FAIL rst_mid_no_done got %0d pulses exp 0", late_done); else pass_cnt++;
        run_pass(1'b0, 1'b0, -1, -1);
        check_cnt++; if (got_data.size() != 12) $display("FAIL rst_new_count got %0d exp 12", got_data.size()); else pass_cnt++;
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check_cnt++; if (got_data[i] !== 8'(exp0[i]) || got_idx[i] != i)
                $display("FAIL rst_new_elem[%0d] got %0d@%0d exp %0d@%0d", i, got_data[i], got_idx[i], exp0[i], i); else pass_cnt++;
        end
        check_cnt++; if (done_cnt != 1) $display("FAIL rst_new_done got %0d exp 1", done_cnt); else pass_cnt++;
    endtask

    task automatic test_relu();
        logic [7:0] exp_r [12];
        for (int i = 0; i < 12; i++) exp_r[i] = 8'(exp0[i]);
`ifdef FLATTEN_RELU_EN
        exp_r[1] = 8'h00; exp_r[4] = 8'h7F; exp_r[9] = 8'h00;
`else
        exp_r[1] = 8'hFB; exp_r[4] = 8'h7F; exp_r[9] = 8'h80;
`endif
        use_override = 1'b1;
        run_pass(1'b0, 1'b0, -1, -1);
        use_override = 1'b0;
        check_cnt++; if (got_data.size() != 12) $display("FAIL relu_count got %0d exp 12", got_data.size()); else pass_cnt++;
        for (int i = 0; i < 12 && i < got_data.size(); i++) begin
            check_cnt++; if (got_data[i] !== exp_r[i] || got_idx[i] != i)
                $display("FAIL relu_elem[%0d] got %h@%0d exp %h@%0d", i, got_data[i], got_idx[i], exp_r[i], i); else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_relu();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    // Global bound in case a wait never completes.
    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/flatten_stream.md
Name: flatten_stream

Overview:
- Sequential, parametrised successor to the combinational flattener.
- Reads the pooled feature-map buffer one element per cycle, then emits a 1D flattened stream over a valid/ready handshake.
- Index and last markers go to the fully-connected stage.
- Supports run-time selectable ordering: channel-major or spatial-major.
- Sits between the pooling layer's output buffer and the FC layer inside the CNN top.

Parameters:
- NUM_FEATURES, 3, number of feature maps (channels).
- POOLED_HEIGHT, 12, rows per pooled map.
- POOLED_WIDTH, 12, columns per pooled map.
- DATA_WIDTH, 8, signed element width.
- FLATTENED_LENGTH, NUM_FEATURES*POOLED_HEIGHT*POOLED_WIDTH, total elements. Elaboration error if overridden inconsistently.
- IDX_WIDTH, $clog2(FLATTENED_LENGTH), output index width.

Ports:
- clock  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- flatten_start  in  1  one-cycle pulse; begins a pass.
- order_mode  in  1  0 = channel-major (f,r,c); 1 = spatial-major (r,c,f). Sampled at accepted start.
- rd_en  out  1  read strobe to pooled buffer.
- rd_feature  out  $clog2(NUM_FEATURES)  read channel.
- rd_row  out  $clog2(POOLED_HEIGHT)  read row.
- rd_col  out  $clog2(POOLED_WIDTH)  read column.
- rd_data  in  DATA_WIDTH signed  element; valid exactly 1 cycle after rd_en.
- out_valid  out  1  flattened element available.
- out_ready  in  1  downstream accepts when high with out_valid.
- out_data  out  DATA_WIDTH signed  flattened element.
- out_index  out  IDX_WIDTH  position in flattened vector, 0..FLATTENED_LENGTH-1.
- out_last  out  1  high with the element whose index is FLATTENED_LENGTH-1.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse after the last element handshakes.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Counters 0.
  - Output FIFO emptied.
  - In-flight read flag cleared.
- Reset mid-pass:
  - Abandons the pass immediately.
  - No done pulse.
  - Data read but not yet emitted is discarded.
- States:
  - IDLE -> RUN on flatten_start; latch order_mode; busy=1 next cycle.
  - RUN: issue reads in order; -> DRAIN after the read for the final element is issued.
  - DRAIN: no reads; wait for the in-flight read and the FIFO to empty via handshakes. -> DONE when the last element handshakes.
  - DONE: done=1 for one cycle, busy=0; -> IDLE.
- flatten_start outside IDLE is ignored and does not restart the pass.
- Address order:
  - Mode 0: col fastest, then row, then feature.
  - Mode 1: feature fastest, then col, then row.
  - Counters wrap at W-1, H-1 and F-1 respectively; out_index increments by 1 per handshake.
- Read latency: 1 cycle. rd_data is captured into a 2-entry output FIFO in the cycle after rd_en.
- Read issue rule (same cycle, combinational): rd_en = (state==RUN) && (fifo_count + inflight - pop) < 2, where pop = out_valid && out_ready.
  - Sustains 1 element/cycle with out_ready held high.
  - Throughput: first out_valid 2 cycles after start is accepted (1 cycle to RUN, 1 read latency).
- out_valid = FIFO non-empty. out_data, out_index and out_last come from the FIFO head.
- Holding rule: while out_valid && !out_ready, these outputs hold stable.
- out_index is attached at read issue and stored with the data.
- Simultaneous push and pop on a full FIFO cannot occur, because the issue rule prevents it.
- Degenerate config: FLATTENED_LENGTH==1 goes RUN->DRAIN after one read; out_last accompanies index 0.
- Data is passed unmodified unless the optional feature is enabled; no width change.

Optional Feature:
- Macro FLATTEN_RELU_EN.
- Defined: each element is clamped to 0 if negative as it is written into the FIFO. out_data = (rd_data<0) ? 0 : rd_data. Index and last are unaffected.
- Undefined: out_data is the exact signed rd_data. No extra logic.

Test Plan:
Test config: F=2, H=2, W=3, DATA_WIDTH=8. Buffer model element = 16*f + 4*r + c; the model returns data 1 cycle after rd_en.
1. Mode 0, out_ready=1 -> out_data sequence 0,1,2,4,5,6,16,17,18,20,21,22.
   - out_index 0..11.
   - out_last only on 22.
   - 12 consecutive valid cycles.
   - done pulse the cycle after the handshake of 22.
2. Mode 1, out_ready=1 -> 0,16,1,17,2,18,4,20,5,21,6,22. out_last on 22.
3. Mode 0, out_ready toggles 1,0,1,0 -> same sequence, no loss or duplication.
   - rd_en never issues when FIFO occupancy plus in-flight reads would exceed 2.
   - Outputs stable while stalled.
4. Pulse flatten_start again at element 5 of a pass -> ignored; 12 elements total, single done.
5. Assert reset for 1 cycle after element 7 handshakes.
   - Next cycle: out_valid=0, busy=0, no done.
   - A new start then yields the full 12-element sequence from index 0.
6. FLATTEN_RELU_EN defined, model returns -5 at (f0,r0,c1) -> out_data 0 at index 1; 127 and -128 at other positions map to 127 and 0.
